icache_refill_assembler: RTL and testbench

Sits between the AXI read shim and the L1 instruction cache refill return port. It assembles AXI R beats into full cache lines, or places a single word for non-cacheable fetches. Assembled lines are buffered in a small return FIFO and presented with a valid/ready handshake. It tracks one outstanding refill, accumulates bus errors, and absorbs the tail of in-flight bursts on flush.

---
 rtl/icache_refill_assembler.sv | 241 ++++++++++++++++++++++++
 tb/tb_icache_refill_assembler.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_assembler.sv
// Refill assembler: R beats -> cache lines, return FIFO, flush drain.
// Optional perf counters: define ICACHE_REFILL_PERF_EN.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   flush_i              drop buffered lines, drain in-flight burst
//   req_valid_i/nc/tid   new refill issued to AXI; req_ready_o when idle
//   beat_*               R channel beats (valid/ready, data, last, err)
//   rtrn_*               assembled line out (valid/ready, data, tid, err)
//   busy_o               burst in flight or lines buffered
//   refill_cnt_o         (perf) lines pushed into the return FIFO
//   stall_cnt_o          (perf) cycles a beat waited while collecting
module icache_refill_assembler #(
  parameter int unsigned LineWidth    = 128,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned Depth        = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    req_valid_i,
  input  logic                    req_nc_i,
  input  logic [IdWidth-1:0]      req_tid_i,
  output logic                    req_ready_o,
  input  logic                    beat_valid_i,
  output logic                    beat_ready_o,
  input  logic [AxiDataWidth-1:0] beat_data_i,
  input  logic                    beat_last_i,
  input  logic                    beat_err_i,
  output logic                    rtrn_valid_o,
  input  logic                    rtrn_ready_i,
  output logic [LineWidth-1:0]    rtrn_data_o,
  output logic [IdWidth-1:0]      rtrn_tid_o,
  output logic                    rtrn_err_o,
  output logic                    busy_o
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0]             refill_cnt_o,
  output logic [31:0]             stall_cnt_o
`endif
);

  localparam int unsigned NBeats = LineWidth / AxiDataWidth;
  localparam int unsigned CW = $clog2(NBeats + 1);
  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned OW = $clog2(Depth + 1);

  localparam logic [CW-1:0] NBeatsC = CW'(NBeats);
  localparam logic [CW:0]   NBeatsX = (CW+1)'(NBeats);
  localparam logic [OW-1:0] DepthC  = OW'(Depth);
  localparam logic [PW-1:0] PtrMax  = PW'(Depth - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_e;

  state_e                state_q;
  logic                  nc_q;
  logic [IdWidth-1:0]    tid_q;
  logic [CW-1:0]         cnt_q;
  logic                  err_q;
  logic [LineWidth-1:0]  line_q;

  logic [LineWidth-1:0]  mem_data [Depth];
  logic [IdWidth-1:0]    mem_tid  [Depth];
  logic                  mem_err  [Depth];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [OW-1:0]         occ_q;

  logic                  fifo_full;
  logic                  beat_fire;
  logic                  collect_fire;
  logic                  over_beat;
  logic                  short_burst;
  logic                  push;
  logic                  pop;
  logic [LineWidth-1:0]  line_nxt;
  logic                  err_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PtrMax) ? '0 : p + PW'(1);
  endfunction

  assign fifo_full   = (occ_q >= DepthC);
  assign req_ready_o = (state_q == IDLE);

  // A last beat needs a free slot now; a pop in the
  // same cycle is deliberately not counted.
  always_comb begin
    beat_ready_o = 1'b0;
    unique case (state_q)
      IDLE:    beat_ready_o = 1'b0;
      COLLECT: beat_ready_o = !beat_last_i || !fifo_full;
      DRAIN:   beat_ready_o = 1'b1;
      default: beat_ready_o = 1'b0;
    endcase
  end

  assign beat_fire    = beat_valid_i && beat_ready_o;
  assign collect_fire = beat_fire && (state_q == COLLECT);

  // nc takes exactly one beat; cacheable takes NBeats.
  assign over_beat = nc_q ? (cnt_q != '0)
                          : (cnt_q >= NBeatsC);

  assign short_burst = !nc_q && beat_last_i &&
                       (({1'b0, cnt_q} + (CW+1)'(1)) < NBeatsX);

  always_comb begin
    line_nxt = line_q;
    err_nxt  = err_q | beat_err_i;
    if (over_beat) begin
      err_nxt = 1'b1;
    end else begin
      for (int w = 0; w < int'(NBeats); w++) begin
        if (CW'(w) == cnt_q) begin
          line_nxt[w*AxiDataWidth +: AxiDataWidth] = beat_data_i;
        end
      end
    end
    if (short_burst) begin
      err_nxt = 1'b1;
    end
  end

  assign push = collect_fire && beat_last_i && !flush_i;
  assign pop  = rtrn_valid_o && rtrn_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      nc_q    <= 1'b0;
      tid_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      line_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            nc_q    <= req_nc_i;
            tid_q   <= req_tid_i;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            line_q  <= '0;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (flush_i) begin
            // A last beat taken with the flush ends the burst here.
            state_q <= (collect_fire && beat_last_i) ? IDLE : DRAIN;
          end else if (collect_fire) begin
            line_q <= line_nxt;
            err_q  <= err_nxt;
            if (cnt_q < NBeatsC) begin
              cnt_q <= cnt_q + CW'(1);
            end
            if (beat_last_i) begin
              state_q <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (beat_fire && beat_last_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_data[i] <= '0;
        mem_tid[i]  <= '0;
        mem_err[i]  <= 1'b0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr_q] <= line_nxt;
        mem_tid[wr_ptr_q]  <= tid_q;
        mem_err[wr_ptr_q]  <= err_nxt;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign rtrn_valid_o = (occ_q != '0);
  assign rtrn_data_o  = mem_data[rd_ptr_q];
  assign rtrn_tid_o   = mem_tid[rd_ptr_q];
  assign rtrn_err_o   = mem_err[rd_ptr_q];
  assign busy_o       = (state_q != IDLE) || (occ_q != '0);

`ifdef ICACHE_REFILL_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      refill_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else if (flush_i) begin
      refill_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else begin
      if (push) begin
        refill_cnt_o <= refill_cnt_o + 32'd1;
      end
      if ((state_q == COLLECT) && beat_valid_i && !beat_ready_o) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end
`endif

  // Only one refill is tracked; the issuer must honour req_ready_o.
  a_req_when_ready: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(req_valid_i && !req_ready_o)
  );

endmodule

// File: tb/tb_icache_refill_assembler.sv
// Bench for icache_refill_assembler: directed scenarios plus a
// randomized run checked against a queue-based line model.
module tb_icache_refill_assembler;

  localparam int LW  = 128;
  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int DEP = 2;
  localparam int NB  = LW / DW;

  typedef struct packed {
    logic [LW-1:0] data;
    logic [IW-1:0] tid;
    logic          err;
  } line_t;

  typedef logic [DW-1:0] word_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_nc_i = 1'b0;
  logic [IW-1:0] req_tid_i = '0;
  logic          req_ready_o;
  logic          beat_valid_i = 1'b0;
  logic          beat_ready_o;
  logic [DW-1:0] beat_data_i = '0;
  logic          beat_last_i = 1'b0;
  logic          beat_err_i = 1'b0;
  logic          rtrn_valid_o;
  logic          rtrn_ready_i = 1'b0;
  logic [LW-1:0] rtrn_data_o;
  logic [IW-1:0] rtrn_tid_o;
  logic          rtrn_err_o;
  logic          busy_o;

  int checks = 0;
  int passed = 0;
  line_t exp_q[$];

  icache_refill_assembler #(
    .LineWidth(LW), .AxiDataWidth(DW),
    .IdWidth(IW), .Depth(DEP)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_nc_i(req_nc_i),
    .req_tid_i(req_tid_i), .req_ready_o(req_ready_o),
    .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o),
    .beat_data_i(beat_data_i), .beat_last_i(beat_last_i),
    .beat_err_i(beat_err_i), .rtrn_valid_o(rtrn_valid_o),
    .rtrn_ready_i(rtrn_ready_i), .rtrn_data_o(rtrn_data_o),
    .rtrn_tid_o(rtrn_tid_o), .rtrn_err_o(rtrn_err_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Line built from the beat list: word i takes beat i for cacheable,
  // only beat 0 for nc; extra or missing beats and bus errors flag it.
  function automatic line_t model(input logic nc,
                                  input logic [IW-1:0] tid,
                                  input word_t d[4],
                                  input bit e[4],
                                  input int n);
    line_t l;
    l.data = '0;
    l.tid  = tid;
    l.err  = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (e[i]) l.err = 1'b1;
      if (nc && i > 0) l.err = 1'b1;
      else if (!nc && i >= NB) l.err = 1'b1;
      else l.data[i*DW +: DW] = d[i];
    end
    if (!nc && n < NB) l.err = 1'b1;
    return l;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_req(input logic [IW-1:0] tid, input logic nc);
    int k = 0;
    while (!req_ready_o && k < 20) begin
      step();
      k++;
    end
    if (!req_ready_o) begin
      checks++;
      $display("FAIL req_wait: req_ready_o stuck at 0");
    end
    req_valid_i = 1'b1;
    req_nc_i    = nc;
    req_tid_i   = tid;
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic send_beat(input word_t d, input logic last,
                           input logic err);
    int k = 0;
    beat_valid_i = 1'b1;
    beat_data_i  = d;
    beat_last_i  = last;
    beat_err_i   = err;
    #1;
    while (!beat_ready_o && k < 20) begin
      step();
      k++;
    end
    if (!beat_ready_o) begin
      checks++;
      $display("FAIL beat_wait: beat_ready_o stuck at 0");
    end
    step();
    beat_valid_i = 1'b0;
    beat_last_i  = 1'b0;
    beat_err_i   = 1'b0;
  endtask

  task automatic refill(input logic [IW-1:0] tid, input logic nc,
                        input word_t d[4], input bit e[4],
                        input int n, input bit gaps);
    do_req(tid, nc);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      send_beat(d[i], (i == n - 1), e[i]);
    end
    exp_q.push_back(model(nc, tid, d, e, n));
  endtask

  task automatic pop_line(output line_t got, output bit ok);
    int k = 0;
    while (!rtrn_valid_o && k < 20) begin
      step();
      k++;
    end
    ok  = rtrn_valid_o;
    got = {rtrn_data_o, rtrn_tid_o, rtrn_err_o};
    rtrn_ready_i = 1'b1;
    step();
    rtrn_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [LW+IW+4:0] obs;
    logic [LW+IW+4:0] exp;
    beat_valid_i = 1'b1;
    #1;
    obs = {req_ready_o, beat_ready_o, rtrn_valid_o, rtrn_data_o,
           rtrn_tid_o, rtrn_err_o, busy_o};
    exp = {1'b1, 1'b0, 1'b0, {LW{1'b0}}, {IW{1'b0}}, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) $display("FAIL reset_out: got %h exp %h", obs, exp);
    else passed++;
    beat_valid_i = 1'b0;
    #13;
    rst_ni = 1'b1;
    step();
    obs = {req_ready_o, beat_ready_o, rtrn_valid_o, rtrn_data_o,
           rtrn_tid_o, rtrn_err_o, busy_o};
    checks++;
    if (obs !== exp) $display("FAIL reset_idle: got %h exp %h", obs, exp);
    else passed++;
  endtask

  task automatic test_cacheable();
    word_t d[4];
    bit e[4];
    line_t got;
    line_t exp;
    bit ok;
    d = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 0, 0};
    e = '{0, 0, 0, 0};
    refill(4'd3, 1'b0, d, e, 2, 1'b0);
    checks++;
    if (rtrn_valid_o !== 1'b1)
      $display("FAIL line_latency: rtrn_valid_o=%b exp 1", rtrn_valid_o);
    else passed++;
    pop_line(got, ok);
    exp = {128'h2222_2222_2222_2222_1111_1111_1111_1111, 4'd3, 1'b0};
    void'(exp_q.pop_front());
    checks++;
    if (!ok || got !== exp)
      $display("FAIL cacheable: got %h exp %h", got, exp);
    else passed++;
  endtask

  task automatic test_nc();
    word_t d[4];
    bit e[4];
    line_t got;
    line_t exp;
    bit ok;
    d = '{64'hABCD, 64'h0, 0, 0};
    e = '{0, 0, 0, 0};
    refill(4'd9, 1'b1, d, e, 1, 1'b0);
    pop_line(got, ok);
    exp = {{64'h0, 64'hABCD}, 4'd9, 1'b0};
    void'(exp_q.pop_front());
    checks++;
    if (!ok || got !== exp)
      $display("FAIL noncacheable: got %h exp %h", got, exp);
    else passed++;
  endtask

  task automatic test_errors();
    word_t d[4];
    bit e[4];
    line_t got;
    line_t exp;
    bit ok;
    d = '{64'h5, 64'h6, 64'h7, 0};
    e = '{1, 0, 0, 0};
    refill(4'd1, 1'b0, d, e, 2, 1'b0);
    pop_line(got, ok);
    exp = {{64'h6, 64'h5}, 4'd1, 1'b1};
    void'(exp_q.pop_front());
    checks++;
    if (!ok || got !== exp) $display("FAIL beat_err: got %h exp %h", got, exp);
    else passed++;
    e = '{0, 0, 0, 0};
    refill(4'd2, 1'b0, d, e, 1, 1'b0);
    pop_line(got, ok);
    exp = {{64'h0, 64'h5}, 4'd2, 1'b1};
    void'(exp_q.pop_front());
    checks++;
    if (!ok || got !== exp) $display("FAIL short_burst: got %h exp %h", got, exp);
    else passed++;
    refill(4'd4, 1'b0, d, e, 3, 1'b0);
    pop_line(got, ok);
    exp = {{64'h6, 64'h5}, 4'd4, 1'b1};
    void'(exp_q.pop_front());
    checks++;
    if (!ok || got !== exp) $display("FAIL long_burst: got %h exp %h", got, exp);
    else passed++;
    refill(4'd6, 1'b1, d, e, 2, 1'b0);
    pop_line(got, ok);
    exp = {{64'h0, 64'h5}, 4'd6, 1'b1};
    void'(exp_q.pop_front());
    checks++;
    if (!ok || got !== exp) $display("FAIL nc_extra: got %h exp %h", got, exp);
    else passed++;
  endtask

  task automatic test_backpressure();
    word_t d[4];
    bit e[4];
    line_t got;
    bit ok;
    e = '{0, 0, 0, 0};
    for (int r = 0; r < 2; r++) begin
      d = '{word_t'(64'hA0 + r), word_t'(64'hB0 + r), 0, 0};
      refill(IW'(r + 7), 1'b0, d, e, 2, 1'b0);
    end
    do_req(4'd12, 1'b0);
    send_beat(64'hC0, 1'b0, 1'b0);
    beat_valid_i = 1'b1;
    beat_data_i  = 64'hC1;
    beat_last_i  = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (beat_ready_o !== 1'b0)
        $display("FAIL full_stall: beat_ready_o=%b exp 0", beat_ready_o);
      else passed++;
      step();
    end
    rtrn_ready_i = 1'b1;
    #1;
    got = {rtrn_data_o, rtrn_tid_o, rtrn_err_o};
    checks++;
    if (beat_ready_o !== 1'b0)
      $display("FAIL pop_same_cycle: beat_ready_o=%b exp 0", beat_ready_o);
    else passed++;
    step();
    rtrn_ready_i = 1'b0;
    checks++;
    if (beat_ready_o !== 1'b1)
      $display("FAIL after_pop: beat_ready_o=%b exp 1", beat_ready_o);
    else passed++;
    step();
    beat_valid_i = 1'b0;
    beat_last_i  = 1'b0;
    d = '{64'hC0, 64'hC1, 0, 0};
    exp_q.push_back(model(1'b0, 4'd12, d, e, 2));
    checks++;
    if (got !== exp_q[0])
      $display("FAIL bp_order0: got %h exp %h", got, exp_q[0]);
    else passed++;
    void'(exp_q.pop_front());
    for (int k = 0; k < 2; k++) begin
      pop_line(got, ok);
      checks++;
      if (!ok || got !== exp_q[0])
        $display("FAIL bp_order: got %h exp %h", got, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_flush();
    word_t d[4];
    bit e[4];
    line_t got;
    bit ok;
    logic [2:0] obs;
    d = '{64'hF0, 64'hF1, 0, 0};
    e = '{0, 0, 0, 0};
    refill(4'd5, 1'b0, d, e, 2, 1'b0);
    exp_q.delete();
    do_req(4'd8, 1'b0);
    send_beat(64'hE0, 1'b0, 1'b0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    obs = {rtrn_valid_o, req_ready_o, busy_o};
    checks++;
    if (obs !== 3'b001) $display("FAIL flush_drain: got %b exp 001", obs);
    else passed++;
    send_beat(64'hE1, 1'b1, 1'b0);
    obs = {rtrn_valid_o, req_ready_o, busy_o};
    checks++;
    if (obs !== 3'b010) $display("FAIL flush_done: got %b exp 010", obs);
    else passed++;
    // Flush while idle does not block a request in the same cycle.
    flush_i     = 1'b1;
    req_valid_i = 1'b1;
    req_tid_i   = 4'd11;
    req_nc_i    = 1'b0;
    step();
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    checks++;
    if (req_ready_o !== 1'b0)
      $display("FAIL flush_idle_req: req_ready_o=%b exp 0", req_ready_o);
    else passed++;
    send_beat(64'hD0, 1'b0, 1'b0);
    send_beat(64'hD1, 1'b1, 1'b0);
    d = '{64'hD0, 64'hD1, 0, 0};
    pop_line(got, ok);
    checks++;
    if (!ok || got !== model(1'b0, 4'd11, d, e, 2))
      $display("FAIL flush_idle_line: got %h", got);
    else passed++;
  endtask

  task automatic test_reset_mid();
    word_t d[4];
    bit e[4];
    line_t got;
    bit ok;
    logic [LW+IW+4:0] obs;
    logic [LW+IW+4:0] exp;
    do_req(4'd13, 1'b0);
    send_beat(64'h77, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    obs = {req_ready_o, beat_ready_o, rtrn_valid_o, rtrn_data_o,
           rtrn_tid_o, rtrn_err_o, busy_o};
    exp = {1'b1, 1'b0, 1'b0, {LW{1'b0}}, {IW{1'b0}}, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) $display("FAIL reset_mid: got %h exp %h", obs, exp);
    else passed++;
    exp_q.delete();
    #12;
    rst_ni = 1'b1;
    step();
    d = '{64'h1234, 64'h5678, 0, 0};
    e = '{0, 0, 0, 0};
    refill(4'd14, 1'b0, d, e, 2, 1'b0);
    pop_line(got, ok);
    checks++;
    if (!ok || got !== exp_q[0])
      $display("FAIL reset_fresh: got %h exp %h", got, exp_q[0]);
    else passed++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    word_t d[4];
    bit e[4];
    line_t got;
    bit ok;
    logic nc;
    int n;
    for (int it = 0; it < 40; it++) begin
      if (exp_q.size() == DEP || (exp_q.size() > 0 && $urandom_range(0, 1))) begin
        pop_line(got, ok);
        checks++;
        if (!ok || got !== exp_q[0])
          $display("FAIL random_line: got %h exp %h", got, exp_q[0]);
        else passed++;
        void'(exp_q.pop_front());
      end
      nc = 1'($urandom_range(0, 2) == 0);
      n  = nc ? ($urandom_range(0, 3) == 0 ? 2 : 1) : $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        d[i] = {$urandom, $urandom};
        e[i] = ($urandom_range(0, 5) == 0);
      end
      refill(IW'($urandom), nc, d, e, n, 1'b1);
    end
    while (exp_q.size() > 0) begin
      pop_line(got, ok);
      checks++;
      if (!ok || got !== exp_q[0])
        $display("FAIL random_tail: got %h exp %h", got, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_cacheable();
    test_nc();
    test_errors();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit hit, %0d/%0d done", passed, checks);
    $fatal(1);
  end

endmodule
